// File: rtl/wb_arith_unit.sv
// Wishbone classic slave arithmetic unit: ADD/SUB finish in one cycle, MUL/MAC run a
// DW-step shift-add and update a 2*DW result/accumulator with sticky status flags.
module wb_arith_unit #(
    parameter int unsigned DW = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [2:0]    wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    output logic          irq_o
);
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e          state;
    logic            ack_q;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic [1:0]      op;
    logic [1:0]      op_run;
    logic            irq_en;
    logic            done;
    logic            carry;
    logic            overrun;
    logic [2*DW-1:0] res;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [2*DW-1:0] prod;
    logic [CW-1:0]   cnt;

    logic            access;
    logic            wr;
    logic            busy;
    logic            guarded;
    logic            finish;
    logic [2*DW-1:0] prod_next;
    logic [2*DW:0]   mac_sum;
    logic [DW:0]     add_sum;
    logic [DW-1:0]   sub_dif;
    logic            borrow;
    logic            unused_dat;

    assign busy       = (state == StCalc);
    assign wb_ack_o   = ack_q & wb_cyc_i & wb_stb_i;
    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr         = access & wb_we_i;
    assign guarded    = (wb_adr_i == 3'd0) || (wb_adr_i == 3'd1) ||
                        (wb_adr_i == 3'd2) || (wb_adr_i == 3'd6);
    assign irq_o      = done & irq_en;
    assign unused_dat = ^wb_dat_i;

    // ADD/SUB reuse the low half of the multiplicand and the multiplier as latched operands.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
        mac_sum   = {1'b0, res} + {1'b0, prod_next};
        add_sum   = {1'b0, mcand[DW-1:0]} + {1'b0, mplier};
        sub_dif   = mcand[DW-1:0] - mplier;
        borrow    = (mcand[DW-1:0] < mplier);
        finish    = busy & (~op_run[1] | (cnt == CW'(DW - 1)));
    end

    always_comb begin
        wb_dat_o = '0;
        case (wb_adr_i)
            3'd0:    wb_dat_o = opa;
            3'd1:    wb_dat_o = opb;
            3'd2:    wb_dat_o[2:0] = {irq_en, op};
            3'd3:    wb_dat_o[3:0] = {overrun, carry, done, busy};
            3'd4:    wb_dat_o = res[DW-1:0];
            3'd5:    wb_dat_o = res[2*DW-1:DW];
            default: wb_dat_o = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= StIdle;
            ack_q   <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            op      <= '0;
            op_run  <= '0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            carry   <= 1'b0;
            overrun <= 1'b0;
            res     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            cnt     <= '0;
        end else begin
            ack_q <= access;
            // W1C first so a completion on the same edge re-sets the flag.
            if (wr && wb_adr_i == 3'd3) begin
                if (wb_dat_i[1]) done <= 1'b0;
                if (wb_dat_i[3]) overrun <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (wr) begin
                        case (wb_adr_i)
                            3'd0: opa <= wb_dat_i;
                            3'd1: opb <= wb_dat_i;
                            3'd2: begin
                                op     <= wb_dat_i[1:0];
                                irq_en <= wb_dat_i[2];
                                if (wb_dat_i[7]) begin
                                    state  <= StCalc;
                                    op_run <= wb_dat_i[1:0];
                                    mcand  <= {{DW{1'b0}}, opa};
                                    mplier <= opb;
                                    prod   <= '0;
                                    cnt    <= '0;
                                    done   <= 1'b0;
                                end
                            end
                            3'd6:    res <= '0;
                            default: ;
                        endcase
                    end
                end
                StCalc: begin
                    if (wr && guarded) overrun <= 1'b1;
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (finish) begin
                        state <= StIdle;
                        done  <= 1'b1;
                        unique case (op_run)
                            2'd0: begin
                                res   <= {{DW{1'b0}}, add_sum[DW-1:0]};
                                carry <= add_sum[DW];
                            end
                            2'd1: begin
                                res   <= {{DW{1'b0}}, sub_dif};
                                carry <= borrow;
                            end
                            2'd2: begin
                                res   <= prod_next;
                                carry <= 1'b0;
                            end
                            2'd3: begin
                                res   <= mac_sum[2*DW-1:0];
                                carry <= mac_sum[2*DW];
                            end
                        endcase
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
